// File: rtl/sad_accum.sv
// Dual-candidate sum-of-absolute-differences accumulator with a running minimum search.
// Define SAD_ACCUM_SAT_EN to make both accumulators saturate instead of wrapping.
module sad_accum #(
    parameter int BLK_LEN   = 16,
    parameter int NUM_PAIRS = 256,
    parameter int SAD_W     = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [7:0]                       c,
    input  logic [7:0]                       p,
    input  logic [7:0]                       p_prime,
    output logic [SAD_W-1:0]                 best_sad,
    output logic [$clog2(2*NUM_PAIRS)-1:0]   best_idx,
    output logic                             busy,
    output logic                             done
);

    localparam int IDX_W  = $clog2(2 * NUM_PAIRS);
    localparam int PAIR_W = IDX_W - 1;
    localparam int PIX_W  = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, FIN} state_t;

    state_t              state;
    logic [PIX_W-1:0]    pix_cnt;
    logic [PAIR_W-1:0]   pair_cnt;
    logic [SAD_W-1:0]    acc0, acc1;
    logic [SAD_W-1:0]    cmp_sad0, cmp_sad1;
    logic [PAIR_W-1:0]   cmp_pair;
    logic                cmp_valid;
    logic [SAD_W-1:0]    sum0, sum1;
    logic [SAD_W-1:0]    nxt_sad;
    logic [IDX_W-1:0]    nxt_idx;
    logic                last_pix, last_pair;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[8] ? 8'(-d) : d[7:0];
    endfunction

    function automatic logic [SAD_W-1:0] acc_add(input logic [SAD_W-1:0] a, input logic [7:0] d);
`ifdef SAD_ACCUM_SAT_EN
        logic [SAD_W:0] s;
        s = {1'b0, a} + (SAD_W+1)'(d);
        return s[SAD_W] ? '1 : s[SAD_W-1:0];
`else
        return a + SAD_W'(d);
`endif
    endfunction

    assign sum0      = acc_add(acc0, abs_diff(c, p));
    assign sum1      = acc_add(acc1, abs_diff(c, p_prime));
    assign last_pix  = (pix_cnt == PIX_W'(BLK_LEN - 1));
    assign last_pair = (pair_cnt == PAIR_W'(NUM_PAIRS - 1));

    // Even candidate is tested first so that it keeps the win on a tie with its odd partner.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        nxt_sad = best_sad;
        nxt_idx = best_idx;
        if (cmp_sad0 < nxt_sad) begin
            nxt_sad = cmp_sad0;
            nxt_idx = {cmp_pair, 1'b0};
        end
        if (cmp_sad1 < nxt_sad) begin
            nxt_sad = cmp_sad1;
            nxt_idx = {cmp_pair, 1'b1};
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            best_sad  <= '1;
            best_idx  <= '0;
            pix_cnt   <= '0;
            pair_cnt  <= '0;
            acc0      <= '0;
            acc1      <= '0;
            cmp_sad0  <= '0;
            cmp_sad1  <= '0;
            cmp_pair  <= '0;
            cmp_valid <= 1'b0;
        end else begin
            done      <= 1'b0;
            cmp_valid <= 1'b0;
            if (cmp_valid) begin
                best_sad <= nxt_sad;
                best_idx <= nxt_idx;
            end

            case (state)
                ACCUM: begin
                    if (last_pix) begin
                        cmp_sad0  <= sum0;
                        cmp_sad1  <= sum1;
                        cmp_pair  <= pair_cnt;
                        cmp_valid <= 1'b1;
                        acc0      <= '0;
                        acc1      <= '0;
                        pix_cnt   <= '0;
                        pair_cnt  <= pair_cnt + PAIR_W'(1);
                        if (last_pair) state <= FLUSH;
                    end else begin
                        acc0    <= sum0;
                        acc1    <= sum1;
                        pix_cnt <= pix_cnt + PIX_W'(1);
                    end
                end
                FLUSH: begin
                    state <= FIN;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase

            // A start in any state wins over the case above: aborts a running search without done.
            if (start) begin
                state     <= ACCUM;
                busy      <= 1'b1;
                done      <= 1'b0;
                best_sad  <= '1;
                best_idx  <= '0;
                pix_cnt   <= '0;
                pair_cnt  <= '0;
                acc0      <= '0;
                acc1      <= '0;
                cmp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sad_accum.sv
// Scoreboard bench for sad_accum: expected results queued at start, popped on each done pulse.
// A second narrow instance exercises wrap/saturation depending on SAD_ACCUM_SAT_EN.
module tb_sad_accum;

    localparam int BLK = 16;
    localparam int NP  = 2;
    localparam int SW  = 16;
    localparam int SWN = 10;

    typedef struct {
        int sad;
        int idx;
        int cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, start_w;
    logic [7:0]    c, p, p_prime;
    logic [SW-1:0] best_sad;
    logic [1:0]    best_idx;
    logic          busy, done;
    logic [SWN-1:0] best_sad_w;
    logic [1:0]    best_idx_w;
    logic          busy_w, done_w;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];
    exp_t e;

    logic [7:0] c_arr [NP][BLK];
    logic [7:0] p_arr [NP][BLK];
    logic [7:0] pp_arr[NP][BLK];

    sad_accum #(.BLK_LEN(BLK), .NUM_PAIRS(NP), .SAD_W(SW)) dut (
        .clk(clk), .reset(reset), .start(start), .c(c), .p(p), .p_prime(p_prime),
        .best_sad(best_sad), .best_idx(best_idx), .busy(busy), .done(done)
    );

    sad_accum #(.BLK_LEN(BLK), .NUM_PAIRS(NP), .SAD_W(SWN)) dut_w (
        .clk(clk), .reset(reset), .start(start_w), .c(c), .p(p), .p_prime(p_prime),
        .best_sad(best_sad_w), .best_idx(best_idx_w), .busy(busy_w), .done(done_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Done monitor: every pulse must match the oldest queued expectation, at the expected cycle.
    always @(negedge clk) begin
        if (!reset && done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cycle=%0d", cyc);
            end else begin
                e = sb.pop_front();
                if (best_sad !== SW'(e.sad)) begin
                    errors++;
                    $display("FAIL best_sad got=%0d exp=%0d", best_sad, e.sad);
                end
                checks++;
                if (best_idx !== 2'(e.idx)) begin
                    errors++;
                    $display("FAIL best_idx got=%0d exp=%0d", best_idx, e.idx);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL done_cycle got=%0d exp=%0d", cyc, e.cyc);
                end
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_at_done got=%b exp=0", busy);
                end
            end
        end
    end

    function automatic void model(input int n_pairs, output int sad, output int idx);
        int sum, r, d;
        sad = (1 << SW) - 1;
        idx = 0;
        for (int k = 0; k < 2 * n_pairs; k++) begin
            sum = 0;
            for (int i = 0; i < BLK; i++) begin
                r = (k % 2 == 1) ? int'(pp_arr[k/2][i]) : int'(p_arr[k/2][i]);
                d = int'(c_arr[k/2][i]) - r;
                sum += (d < 0) ? -d : d;
            end
            if (sum < sad) begin
                sad = sum;
                idx = k;
            end
        end
    endfunction

    task automatic fill_pair(input int k, input int cv, input int pv, input int ppv);
        for (int i = 0; i < BLK; i++) begin
            c_arr[k][i]  = 8'(cv);
            p_arr[k][i]  = 8'(pv);
            pp_arr[k][i] = 8'(ppv);
        end
    endtask

    // Pulses start, then feeds n_pix pixel cycles; queues a result only for a search that completes.
    task automatic drive_search(input int n_pix, input bit expect_done);
        exp_t x;
        @(posedge clk); #1;
        start = 1'b1;
        if (expect_done) begin
            model(NP, x.sad, x.idx);
            x.cyc = cyc + NP * BLK + 2;
            sb.push_back(x);
        end
        for (int j = 0; j < n_pix; j++) begin
            @(posedge clk); #1;
            start   = 1'b0;
            c       = c_arr[j/BLK][j%BLK];
            p       = p_arr[j/BLK][j%BLK];
            p_prime = pp_arr[j/BLK][j%BLK];
            if (j == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_after_start got=%b exp=1", busy);
                end
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL done_timeout pending=%0d exp=0", sb.size());
            sb.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++;
        if (best_sad !== '1) begin errors++; $display("FAIL reset_best_sad got=%0h exp=ffff", best_sad); end
        checks++;
        if (best_idx !== 2'd0) begin errors++; $display("FAIL reset_best_idx got=%0d exp=0", best_idx); end
    endtask

    task automatic test_min_zero();
        for (int k = 0; k < NP; k++) fill_pair(k, 100, 100, 90);
        drive_search(NP * BLK, 1'b1);
        wait_idle();
    endtask

    task automatic test_pair_select();
        fill_pair(0, 100, 110, 105);
        fill_pair(1, 100, 101, 103);
        drive_search(NP * BLK, 1'b1);
        wait_idle();
    endtask

    task automatic test_ties();
        for (int k = 0; k < NP; k++) fill_pair(k, 100, 110, 90);
        drive_search(NP * BLK, 1'b1);
        wait_idle();
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NP; k++)
                for (int i = 0; i < BLK; i++) begin
                    c_arr[k][i]  = 8'($urandom_range(0, 255));
                    p_arr[k][i]  = 8'($urandom_range(0, 255));
                    pp_arr[k][i] = 8'($urandom_range(0, 255));
                end
            drive_search(NP * BLK, 1'b1);
            wait_idle();
        end
    endtask

    // Second start lands exactly in FIN of the first search: both done pulses expected.
    task automatic test_back_to_back();
        fill_pair(0, 50, 60, 45);
        fill_pair(1, 50, 52, 70);
        drive_search(NP * BLK, 1'b1);
        @(posedge clk); #1;
        c = 8'd0;
        fill_pair(0, 200, 180, 205);
        fill_pair(1, 200, 199, 230);
        drive_search(NP * BLK, 1'b1);
        wait_idle();
    endtask

    // First search would find SAD 0 before being aborted; only the second result may appear.
    task automatic test_abort();
        for (int k = 0; k < NP; k++) fill_pair(k, 100, 100, 100);
        drive_search(19, 1'b0);
        fill_pair(0, 100, 110, 105);
        fill_pair(1, 100, 101, 103);
        drive_search(NP * BLK, 1'b1);
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int ps, pi;
        fill_pair(0, 100, 110, 105);
        fill_pair(1, 100, 101, 103);
        model(1, ps, pi);
        drive_search(20, 1'b0);
        checks++;
        if (best_sad !== SW'(ps)) begin errors++; $display("FAIL mid_best_sad got=%0d exp=%0d", best_sad, ps); end
        checks++;
        if (best_idx !== 2'(pi)) begin errors++; $display("FAIL mid_best_idx got=%0d exp=%0d", best_idx, pi); end
        #2 reset = 1'b1;
        #1;
        test_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int n = 0; n < 10; n++) begin
            c = 8'($urandom_range(0, 255));
            p = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy got=%b exp=0", busy); end
        checks++;
        if (best_sad !== '1) begin errors++; $display("FAIL idle_after_reset best_sad got=%0h exp=ffff", best_sad); end
        wait_idle();
    endtask

    task automatic test_saturation();
        int exp_sad;
        bit got;
`ifdef SAD_ACCUM_SAT_EN
        exp_sad = (1 << SWN) - 1;
`else
        exp_sad = (BLK * 255) % (1 << SWN);
`endif
        @(posedge clk); #1;
        start_w = 1'b1;
        for (int j = 0; j < NP * BLK; j++) begin
            @(posedge clk); #1;
            start_w = 1'b0;
            c = 8'd255; p = 8'd0; p_prime = 8'd0;
            if (j == 0) begin
                checks++;
                if (busy_w !== 1'b1) begin errors++; $display("FAIL sat_busy got=%b exp=1", busy_w); end
            end
        end
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (done_w) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL sat_done_timeout got=0 exp=1");
        end else begin
            checks++;
            if (best_sad_w !== SWN'(exp_sad)) begin
                errors++;
                $display("FAIL sat_best_sad got=%0d exp=%0d", best_sad_w, exp_sad);
            end
            checks++;
            if (best_idx_w !== 2'd0) begin
                errors++;
                $display("FAIL sat_best_idx got=%0d exp=0", best_idx_w);
            end
        end
        wait_idle();
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        start_w = 1'b0;
        c       = 8'd0;
        p       = 8'd0;
        p_prime = 8'd0;
        #1;
        test_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        test_min_zero();
        test_pair_select();
        test_ties();
        test_random();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
